// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: splits the instruction window, predicts the next PC
// and holds the F and F->D pipeline registers. Optional: IMEM_BOUNDS_EN.
module fetch_unit #(
  parameter int unsigned IMEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] f_pc,
  input  logic [79:0] imem_instr,
  input  logic        imem_error,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  output logic [63:0] imem_addr,
  output logic [63:0] F_predPC,
  output logic [3:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_t;

  localparam d_t BUBBLE = '{
    stat:  4'h1,
    icode: 4'h1,
    ifun:  4'h0,
    ra:    4'hF,
    rb:    4'hF,
    valc:  64'd0,
    valp:  64'd0
  };

  function automatic logic has_regids(input logic [3:0] c);
    return c inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
  endfunction

  function automatic logic has_valc(input logic [3:0] c);
    return c inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
  endfunction

  logic [7:0]  b0;
  logic [7:0]  b1;
  logic [3:0]  raw_icode;
  logic [63:0] raw_len;
  logic        bnd_err;
  logic        fault;
  logic [3:0]  icode;
  logic        need_regids;
  logic        need_valc;
  logic [63:0] f_predpc;
  d_t          f_d;
  d_t          d_q;

  assign b0        = imem_instr[7:0];
  assign b1        = imem_instr[15:8];
  assign imem_addr = f_pc;

  // Length is taken before the bounds check forces a NOP.
  assign raw_icode = imem_error ? 4'h1 : b0[7:4];
  assign raw_len   = 64'd1
                   + {63'd0, has_regids(raw_icode)}
                   + (has_valc(raw_icode) ? 64'd8 : 64'd0);

`ifdef IMEM_BOUNDS_EN
  logic [64:0] end_addr;
  assign end_addr = {1'b0, f_pc} + {1'b0, raw_len};
  assign bnd_err  = end_addr > 65'(IMEM_BYTES);
`else
  logic unused_bnd;
  assign unused_bnd = |{IMEM_BYTES, raw_len};
  assign bnd_err    = 1'b0;
`endif

  assign fault       = imem_error | bnd_err;
  assign icode       = fault ? 4'h1 : b0[7:4];
  assign need_regids = has_regids(icode);
  assign need_valc   = has_valc(icode);

  always_comb begin
    f_d       = BUBBLE;
    f_d.icode = icode;
    f_d.ifun  = fault ? 4'h0 : b0[3:0];
    f_d.ra    = need_regids ? b1[7:4] : 4'hF;
    f_d.rb    = need_regids ? b1[3:0] : 4'hF;
    f_d.valc  = 64'd0;
    if (need_valc)
      f_d.valc = need_regids ? imem_instr[79:16]
                             : imem_instr[71:8];
    f_d.valp  = f_pc + 64'd1
              + {63'd0, need_regids}
              + (need_valc ? 64'd8 : 64'd0);
    unique case (1'b1)
      fault:          f_d.stat = 4'h3;
      (icode > 4'hB): f_d.stat = 4'h4;
      (icode == 4'h0): f_d.stat = 4'h2;
      default:        f_d.stat = 4'h1;
    endcase
  end

  // jXX is predicted taken; call always redirects.
  assign f_predpc = (icode == 4'h7 || icode == 4'h8)
                  ? f_d.valc : f_d.valp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      F_predPC <= 64'd0;
      d_q      <= BUBBLE;
    end else begin
      if (!F_stall)
        F_predPC <= f_predpc;
      if (D_stall)
        d_q <= d_q;
      else if (D_bubble)
        d_q <= BUBBLE;
      else
        d_q <= f_d;
    end
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps then random traffic, all checked
// against a byte-level reference model of the fetch rules.
module tb_fetch_unit;

`ifdef IMEM_BOUNDS_EN
  localparam int unsigned IMEM = 64;
`else
  localparam int unsigned IMEM = 8192;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] f_pc;
  logic [79:0] imem_instr;
  logic        imem_error;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic [63:0] imem_addr;
  logic [63:0] F_predPC;
  logic [3:0]  D_stat;
  logic [3:0]  D_icode;
  logic [3:0]  D_ifun;
  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_pred, m_valc, m_valp;
  logic [3:0]  m_stat, m_icode, m_ifun, m_ra, m_rb;

  logic [63:0] e_pred, e_valc, e_valp;
  logic [3:0]  e_stat, e_icode, e_ifun, e_ra, e_rb;

  fetch_unit #(.IMEM_BYTES(IMEM)) dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
    .imem_instr(imem_instr), .imem_error(imem_error),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .imem_addr(imem_addr), .F_predPC(F_predPC),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_fetch();
    byte unsigned b[10];
    int ic, fn, regs, cons, len, off;
    logic adr;
    longint unsigned vc, endp;
    for (int i = 0; i < 10; i++) b[i] = imem_instr[8*i +: 8];
    ic   = b[0] >> 4;
    fn   = b[0] & 15;
    adr  = imem_error;
    if (adr) ic = 1;
    regs = (ic inside {2, 3, 4, 5, 6, 10, 11}) ? 1 : 0;
    cons = (ic inside {3, 4, 5, 7, 8}) ? 1 : 0;
    len  = 1 + regs + 8 * cons;
`ifdef IMEM_BOUNDS_EN
    endp = f_pc + 64'(len);
    if (endp < f_pc || endp > 64'(IMEM)) adr = 1'b1;
`endif
    if (adr) begin
      ic = 1;
      fn = 0;
    end
    regs = (ic inside {2, 3, 4, 5, 6, 10, 11}) ? 1 : 0;
    cons = (ic inside {3, 4, 5, 7, 8}) ? 1 : 0;
    len  = 1 + regs + 8 * cons;
    vc   = 0;
    if (cons != 0) begin
      off = 1 + regs;
      for (int i = 0; i < 8; i++)
        vc = vc | (longint'(b[off+i]) << (8 * i));
    end
    m_icode = 4'(ic);
    m_ifun  = 4'(fn);
    m_ra    = (regs != 0) ? 4'(b[1] >> 4) : 4'hF;
    m_rb    = (regs != 0) ? 4'(b[1] & 15) : 4'hF;
    m_valc  = vc;
    m_valp  = f_pc + 64'(len);
    m_pred  = (ic == 7 || ic == 8) ? vc : m_valp;
    if (adr)          m_stat = 4'h3;
    else if (ic > 11) m_stat = 4'h4;
    else if (ic == 0) m_stat = 4'h2;
    else              m_stat = 4'h1;
  endtask

  task automatic exp_bubble();
    e_stat = 4'h1; e_icode = 4'h1; e_ifun = 4'h0;
    e_ra = 4'hF; e_rb = 4'hF; e_valc = 64'd0; e_valp = 64'd0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".predPC"}, F_predPC, e_pred);
    chk({tag, ".stat"},   64'(D_stat),  64'(e_stat));
    chk({tag, ".icode"},  64'(D_icode), 64'(e_icode));
    chk({tag, ".ifun"},   64'(D_ifun),  64'(e_ifun));
    chk({tag, ".rA"},     64'(D_rA),    64'(e_ra));
    chk({tag, ".rB"},     64'(D_rB),    64'(e_rb));
    chk({tag, ".valC"},   D_valC, e_valc);
    chk({tag, ".valP"},   D_valP, e_valp);
  endtask

  task automatic drive(input string tag, input logic [63:0] pc,
                       input logic [79:0] win, input logic err,
                       input logic fs, input logic ds,
                       input logic db, input logic rn);
    f_pc = pc; imem_instr = win; imem_error = err;
    F_stall = fs; D_stall = ds; D_bubble = db; rst_n = rn;
    #1;
    chk({tag, ".addr"}, imem_addr, pc);
    model_fetch();
    if (!rn) begin
      e_pred = 64'd0;
      exp_bubble();
    end else begin
      if (!fs) e_pred = m_pred;
      if (!ds) begin
        if (db) exp_bubble();
        else begin
          e_stat = m_stat; e_icode = m_icode; e_ifun = m_ifun;
          e_ra = m_ra; e_rb = m_rb; e_valc = m_valc; e_valp = m_valp;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  localparam logic [79:0] IRMOV = 80'h0000_0000_0000_000A_F230;
  localparam logic [79:0] JXX   = 80'h0000_0000_0000_0001_0070;
  localparam logic [79:0] CALL  = 80'h0000_0000_0000_0001_0080;

  initial begin
    logic [63:0] pc;
    logic [79:0] win;
    e_pred = '0;
    exp_bubble();
    drive("rst0", 64'h0, IRMOV, 0, 0, 0, 0, 0);
    drive("rst1", 64'h5, JXX, 0, 0, 0, 0, 0);
    chk("rst.icode_c", 64'(D_icode), 64'h1);
    drive("irmovq", 64'h0, IRMOV, 0, 0, 0, 0, 1);
    chk("irmovq.valC_c", D_valC, 64'h0A);
    chk("irmovq.rB_c", 64'(D_rB), 64'h2);
    chk("irmovq.pred_c", F_predPC, 64'h0A);
    drive("jxx", 64'h20, JXX, 0, 0, 0, 0, 1);
    chk("jxx.valP_c", D_valP, 64'h29);
    chk("jxx.pred_c", F_predPC, 64'h100);
    drive("call", 64'h20, CALL, 0, 0, 0, 0, 1);
    drive("ret", 64'h40, 80'h90, 0, 0, 0, 0, 1);
    chk("ret.valP_c", D_valP, 64'h41);
    drive("ins", 64'h41, 80'hC0, 0, 0, 0, 0, 1);
    chk("ins.stat_c", 64'(D_stat), 64'h4);
    drive("hlt", 64'h42, 80'h00, 0, 0, 0, 0, 1);
    drive("adr", 64'h43, IRMOV, 1, 0, 0, 0, 1);
    chk("adr.stat_c", 64'(D_stat), 64'h3);
    drive("load", 64'h0, IRMOV, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      drive("stall", 64'(8 * i + 16), JXX, 0, 1, 1, 0, 1);
    chk("stall.pred_c", F_predPC, 64'h0A);
    drive("release", 64'h20, JXX, 0, 0, 0, 0, 1);
    drive("fonly", 64'h0, IRMOV, 0, 1, 0, 0, 1);
    drive("bubble", 64'h40, 80'h90, 0, 0, 0, 1, 1);
    chk("bubble.valP_c", D_valP, 64'h0);
    drive("reload", 64'h0, IRMOV, 0, 0, 0, 0, 1);
    drive("bub_stall", 64'h20, JXX, 0, 0, 1, 1, 1);
    drive("rst_mid", 64'h20, JXX, 0, 1, 1, 0, 0);
    drive("bnd", 64'h38, IRMOV, 0, 0, 0, 0, 1);
    drive("wrap", 64'hFFFF_FFFF_FFFF_FFFA, IRMOV, 0, 0, 0, 0, 1);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       pc = {$urandom(), $urandom()};
        1:       pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        default: pc = 64'($urandom_range(0, 80));
      endcase
      win = {$urandom(), $urandom(), 16'($urandom())};
      drive("rand", pc, win,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 31) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
